frac_alu_pipe: RTL and testbench

//   Pipelined, parametrised sign-magnitude fraction adder/subtractor for the FP datapath; successor of the 6-bit combinational fraction ALU.

---
 rtl/frac_alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_frac_alu_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_alu_pipe.sv
// rtl/frac_alu_pipe.sv - pipelined sign-magnitude fraction add/subtract with valid/ready, zero flag and tag
module frac_alu_pipe #(
  parameter int FRAC_W = 6,
  parameter int PIPE   = 2,
  parameter int TAG_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [FRAC_W-1:0] LARGER_FRAC,
  input  logic [FRAC_W-1:0] SHIFT_FRAC,
  input  logic              L_SIGN,
  input  logic              S_SIGN,
  input  logic              ADDSUB,
  input  logic              OPERAND,
  input  logic [TAG_W-1:0]  TAG,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [FRAC_W:0]   TEMP_FRAC,
  output logic              RESULT_SIGN,
  output logic              ZERO,
  output logic [TAG_W-1:0]  OUT_TAG
);

  localparam int W = FRAC_W + 2;

  logic             en;
  logic [W-1:0]     in_l;
  logic [W-1:0]     in_s;

  logic             op_valid;
  logic [W-1:0]     op_l;
  logic [W-1:0]     op_s;
  logic             op_sub;
  logic             op_ord;
  logic [TAG_W-1:0] op_tag;

  logic [W-1:0]     r;
  logic             res_sign;
  logic             res_zero;
  logic [FRAC_W:0]  res_frac;

  logic             out_valid_q, out_valid_d;
  logic [FRAC_W:0]  out_frac_q, out_frac_d;
  logic             out_sign_q, out_sign_d;
  logic             out_zero_q, out_zero_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // The whole pipe advances together; only a stalled valid output blocks it.
  assign en       = ~out_valid_q | OUT_READY;
  assign IN_READY = en;

  always_comb begin
    in_l = L_SIGN ? -{2'b00, LARGER_FRAC} : {2'b00, LARGER_FRAC};
    in_s = S_SIGN ? -{2'b00, SHIFT_FRAC}  : {2'b00, SHIFT_FRAC};
  end

  generate
    if (PIPE == 1) begin : g_pipe1
      assign op_valid = IN_VALID;
      assign op_l     = in_l;
      assign op_s     = in_s;
      assign op_sub   = ADDSUB;
      assign op_ord   = OPERAND;
      assign op_tag   = TAG;
    end else begin : g_pipe2
      logic             s1_valid_q, s1_valid_d;
      logic [W-1:0]     s1_l_q, s1_l_d;
      logic [W-1:0]     s1_s_q, s1_s_d;
      logic             s1_sub_q, s1_sub_d;
      logic             s1_ord_q, s1_ord_d;
      logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_l_d     = s1_l_q;
        s1_s_d     = s1_s_q;
        s1_sub_d   = s1_sub_q;
        s1_ord_d   = s1_ord_q;
        s1_tag_d   = s1_tag_q;
        if (en) begin
          s1_valid_d = IN_VALID;
          s1_l_d     = in_l;
          s1_s_d     = in_s;
          s1_sub_d   = ADDSUB;
          s1_ord_d   = OPERAND;
          s1_tag_d   = TAG;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_valid_q <= 1'b0;
          s1_l_q     <= '0;
          s1_s_q     <= '0;
          s1_sub_q   <= 1'b0;
          s1_ord_q   <= 1'b0;
          s1_tag_q   <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_l_q     <= s1_l_d;
          s1_s_q     <= s1_s_d;
          s1_sub_q   <= s1_sub_d;
          s1_ord_q   <= s1_ord_d;
          s1_tag_q   <= s1_tag_d;
        end
      end

      assign op_valid = s1_valid_q;
      assign op_l     = s1_l_q;
      assign op_s     = s1_s_q;
      assign op_sub   = s1_sub_q;
      assign op_ord   = s1_ord_q;
      assign op_tag   = s1_tag_q;
    end
  endgenerate

  // Two extra bits of headroom: |R| <= 2*(2^FRAC_W-1) never wraps.
  always_comb begin
    r = '0;
    if (op_ord) begin
      r = op_sub ? (op_l - op_s) : (op_l + op_s);
    end else begin
      r = op_sub ? (op_s - op_l) : (op_s + op_l);
    end
    res_sign = r[W-1];
    res_zero = (r == '0);
    res_frac = res_sign ? (FRAC_W+1)'(-r) : r[FRAC_W:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_frac_d  = out_frac_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_tag_d   = out_tag_q;
    if (en) begin
      out_valid_d = op_valid;
      out_frac_d  = res_frac;
      out_sign_d  = res_sign;
      out_zero_d  = res_zero;
      out_tag_d   = op_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_frac_q  <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_frac_q  <= out_frac_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign TEMP_FRAC   = out_frac_q;
  assign RESULT_SIGN = out_sign_q;
  assign ZERO        = out_zero_q;
  assign OUT_TAG     = out_tag_q;

endmodule

// File: tb/tb_frac_alu_pipe.sv
// tb/tb_frac_alu_pipe.sv - scoreboard bench for frac_alu_pipe at PIPE=2 (dut 0) and PIPE=1 (dut 1)
module tb_frac_alu_pipe;
  localparam int FW = 6;
  localparam int TW = 4;

  typedef struct {
    logic [FW:0]   frac;
    logic          sign;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    int lf; int ls; int sf; int ss; int sub; int ord; int ef; int es;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]         in_valid, in_ready, l_sign, s_sign, addsub, operand;
  logic [1:0]         out_valid, out_ready, res_sign, zero;
  logic [1:0][FW-1:0] lfrac, sfrac;
  logic [1:0][TW-1:0] tag, out_tag;
  logic [1:0][FW:0]   tfrac;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   accepted[2];
  int   delivered[2];
  logic          stall_prev[2];
  logic [FW:0]   prev_frac[2];
  logic          prev_sign[2];
  logic          prev_zero[2];
  logic [TW-1:0] prev_tag[2];
  vec_t vt[8];

  frac_alu_pipe #(.FRAC_W(FW), .PIPE(2), .TAG_W(TW)) u_dut2 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .LARGER_FRAC(lfrac[0]), .SHIFT_FRAC(sfrac[0]), .L_SIGN(l_sign[0]), .S_SIGN(s_sign[0]),
    .ADDSUB(addsub[0]), .OPERAND(operand[0]), .TAG(tag[0]), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready[0]), .TEMP_FRAC(tfrac[0]), .RESULT_SIGN(res_sign[0]),
    .ZERO(zero[0]), .OUT_TAG(out_tag[0])
  );

  frac_alu_pipe #(.FRAC_W(FW), .PIPE(1), .TAG_W(TW)) u_dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .LARGER_FRAC(lfrac[1]), .SHIFT_FRAC(sfrac[1]), .L_SIGN(l_sign[1]), .S_SIGN(s_sign[1]),
    .ADDSUB(addsub[1]), .OPERAND(operand[1]), .TAG(tag[1]), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready[1]), .TEMP_FRAC(tfrac[1]), .RESULT_SIGN(res_sign[1]),
    .ZERO(zero[1]), .OUT_TAG(out_tag[1])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [FW-1:0] lf, input logic [FW-1:0] sf,
                                 input logic ls, input logic ss, input logic sub,
                                 input logic ord, input logic [TW-1:0] t);
    exp_t e;
    int l, s, r;
    l = ls ? -int'(lf) : int'(lf);
    s = ss ? -int'(sf) : int'(sf);
    if (ord) r = sub ? l - s : l + s;
    else     r = sub ? s - l : s + l;
    e.frac = (FW+1)'(r < 0 ? -r : r);
    e.sign = (r < 0);
    e.zero = (r == 0);
    e.tag  = t;
    return e;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int pipe_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Scoreboard: push on accept, pop and compare on delivery, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (d == 0) q0.delete(); else q1.delete();
        stall_prev[d] = 1'b0;
      end else begin
        if (stall_prev[d]) begin
          chk("hold_valid", out_valid[d], 1'b1);
          chk("hold_frac", tfrac[d], prev_frac[d]);
          chk("hold_sign", res_sign[d], prev_sign[d]);
          chk("hold_zero", zero[d], prev_zero[d]);
          chk("hold_tag", out_tag[d], prev_tag[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          if (qsize(d) == 0) begin
            chk("unexpected_out", qsize(d), 1);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk("sb_frac", tfrac[d], e.frac);
            chk("sb_sign", res_sign[d], e.sign);
            chk("sb_zero", zero[d], e.zero);
            chk("sb_tag", out_tag[d], e.tag);
            delivered[d]++;
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          e = model(lfrac[d], sfrac[d], l_sign[d], s_sign[d], addsub[d], operand[d], tag[d]);
          if (d == 0) q0.push_back(e); else q1.push_back(e);
          accepted[d]++;
        end
        stall_prev[d] = out_valid[d] && !out_ready[d];
        prev_frac[d]  = tfrac[d];
        prev_sign[d]  = res_sign[d];
        prev_zero[d]  = zero[d];
        prev_tag[d]   = out_tag[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int lf, input int ls, input int sf, input int ss,
                      input int sub, input int ord, input int tg);
    int n;
    lfrac[d]    = FW'(lf);
    sfrac[d]    = FW'(sf);
    l_sign[d]   = ls[0];
    s_sign[d]   = ss[0];
    addsub[d]   = sub[0];
    operand[d]  = ord[0];
    tag[d]      = TW'(tg);
    in_valid[d] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[d] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    step();
    in_valid[d] = 1'b0;
  endtask

  task automatic directed(input int d, input vec_t v, input int tg);
    out_ready[d] = 1'b1;
    send(d, v.lf, v.ls, v.sf, v.ss, v.sub, v.ord, tg);
    if (pipe_of(d) == 2) begin
      chk("lat_early", out_valid[d], 1'b0);
      step();
    end
    chk("lat_valid", out_valid[d], 1'b1);
    chk("dir_frac", tfrac[d], v.ef);
    chk("dir_sign", res_sign[d], v.es);
    chk("dir_zero", zero[d], (v.ef == 0));
    chk("dir_tag", out_tag[d], tg);
    step();
  endtask

  task automatic drain(input int d, input string name);
    int n;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    n = 0;
    while (qsize(d) != 0 && n < 50) begin
      step();
      n++;
    end
    chk(name, qsize(d), 0);
  endtask

  initial begin
    int i, cyc, d0, n;
    logic acc;
    vt[0] = '{20, 0, 5, 0, 0, 1, 25, 0};
    vt[1] = '{20, 1, 5, 0, 0, 1, 15, 1};
    vt[2] = '{20, 0, 5, 0, 1, 0, 15, 1};
    vt[3] = '{20, 0, 5, 0, 1, 1, 15, 0};
    vt[4] = '{63, 0, 63, 0, 0, 1, 126, 0};
    vt[5] = '{63, 1, 63, 0, 1, 1, 126, 1};
    vt[6] = '{10, 0, 10, 0, 1, 1, 0, 0};
    vt[7] = '{0, 1, 0, 1, 0, 1, 0, 0};

    rst = 1'b1;
    in_valid = '0; l_sign = '0; s_sign = '0; addsub = '0; operand = '0;
    lfrac = '0; sfrac = '0; tag = '0;
    out_ready = 2'b11;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", out_valid[d], 1'b0);
      chk("rst_frac", tfrac[d], 0);
      chk("rst_sign", res_sign[d], 1'b0);
      chk("rst_zero", zero[d], 1'b0);
      chk("rst_tag", out_tag[d], 0);
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) chk("rst_in_ready", in_ready[d], 1'b1);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) directed(d, vt[k], k);

    // Back-to-back stream with a three-cycle downstream stall in the middle.
    for (int d = 0; d < 2; d++) begin
      d0 = delivered[d];
      i = 0;
      cyc = 0;
      while (i < 8 && cyc < 60) begin
        lfrac[d]     = FW'(7 * i + 3);
        sfrac[d]     = FW'(i);
        l_sign[d]    = i[0];
        s_sign[d]    = 1'b0;
        addsub[d]    = i[1];
        operand[d]   = i[2];
        tag[d]       = TW'(i);
        in_valid[d]  = 1'b1;
        out_ready[d] = !(cyc >= 3 && cyc <= 5);
        #1;
        if (cyc >= 3 && cyc <= 5) chk("b2b_ready_low", in_ready[d], 1'b0);
        acc = in_valid[d] && in_ready[d];
        step();
        if (acc) i++;
        cyc++;
      end
      chk("b2b_sent", i, 8);
      drain(d, "b2b_drain");
      chk("b2b_count", delivered[d] - d0, 8);
    end

    // Reset with results in flight: nothing stale may come out afterwards.
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0;
      send(d, 9, 0, 4, 0, 0, 1, 11);
      if (pipe_of(d) == 2) send(d, 3, 1, 2, 0, 1, 0, 12);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid[d], 1'b0);
      chk("mid_rst_frac", tfrac[d], 0);
      chk("mid_rst_tag", out_tag[d], 0);
      chk("mid_rst_in_ready", in_ready[d], 1'b1);
      out_ready[d] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("no_stale", out_valid[d], 1'b0);
      end
      directed(d, vt[1], 5);
    end

    // Random traffic on both pipes at once, 5000 vectors each.
    accepted[0] = 0;
    accepted[1] = 0;
    n = 0;
    while ((accepted[0] < 5000 || accepted[1] < 5000) && n < 40000) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = (accepted[d] < 5000) && ($urandom_range(0, 3) != 0);
        lfrac[d]     = FW'($urandom);
        sfrac[d]     = FW'($urandom);
        l_sign[d]    = 1'($urandom);
        s_sign[d]    = 1'($urandom);
        addsub[d]    = 1'($urandom);
        operand[d]   = 1'($urandom);
        tag[d]       = TW'($urandom);
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      step();
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk("rand_accepted", accepted[d] >= 5000, 1'b1);
      drain(d, "rand_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
